// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched: shares the regfile write port between the ALU (A) and a FIFO-buffered
// long-latency unit (B), with a busy-bit scoreboard that stalls decode on RAW/WAW hazards.
module regfile_wb_sched #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_add,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_add,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic        issue_writes,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  issue_rs1,
  input  logic [4:0]  issue_rs2,
  output logic        stall,
  output logic        write_enable,
  output logic [4:0]  write_add,
  output logic [31:0] z5_output,
  output logic [31:0] busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [4:0]    fa_q [FIFO_DEPTH];
  logic [4:0]    fa_d [FIFO_DEPTH];
  logic [31:0]   fd_q [FIFO_DEPTH];
  logic [31:0]   fd_d [FIFO_DEPTH];
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [3:0]    starve_q, starve_d;
  logic          we_q, we_d;
  logic [4:0]    wa_q, wa_d;
  logic [31:0]   wd_q, wd_d;
  logic [31:0]   busy_q, busy_d;
  logic          non_empty, force_b, a_win, pop, commit, push;
  logic [4:0]    win_add;
  logic [31:0]   win_data;

  always_comb begin
    non_empty = cnt_q != '0;
    force_b   = non_empty && starve_q >= LIMIT;
    a_win     = a_valid && !force_b;
    pop       = !a_win && non_empty;
    commit    = a_win || pop;
    win_add   = a_win ? a_add : fa_q[rp_q];
    win_data  = a_win ? a_data : fd_q[rp_q];
    a_ready   = a_win;
    b_ready   = cnt_q < DEPTH;
    push      = b_valid && b_ready;
    // Registered busy only: a same-cycle commit does not unblock decode until next cycle.
    stall     = issue_valid && (busy_q[issue_rs1] || busy_q[issue_rs2] || (issue_writes && busy_q[issue_rd]));
    fa_d      = fa_q;
    fd_d      = fd_q;
    if (push) begin
      fa_d[wp_q] = b_add;
      fd_d[wp_q] = b_data;
    end
    wp_d      = push ? wp_q + 1'b1 : wp_q;
    rp_d      = pop ? rp_q + 1'b1 : rp_q;
    cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    starve_d  = (non_empty && a_win) ? (starve_q == 4'hf ? starve_q : starve_q + 1'b1) : '0;
    we_d      = commit && win_add != 5'd0;
    wa_d      = commit ? win_add : wa_q;
    wd_d      = commit ? win_data : wd_q;
    busy_d    = busy_q;
    if (commit) busy_d[win_add] = 1'b0;
    if (issue_valid && !stall && issue_writes) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fa_q     <= '{default: '0};
      fd_q     <= '{default: '0};
      rp_q     <= '0;
      wp_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
      busy_q   <= '0;
    end else begin
      fa_q     <= fa_d;
      fd_q     <= fd_d;
      rp_q     <= rp_d;
      wp_q     <= wp_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      busy_q   <= busy_d;
    end
  end

  assign write_enable = we_q;
  assign write_add    = wa_q;
  assign z5_output    = wd_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_regfile_wb_sched.sv
// tb_regfile_wb_sched: scenario tasks plus a reference model that queues expected commits,
// drained and compared against the regfile write outputs every cycle.
module tb_regfile_wb_sched;
  logic        clk, reset;
  logic        a_valid, b_valid, issue_valid, issue_writes;
  logic [4:0]  a_add, b_add, issue_rd, issue_rs1, issue_rs2;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, stall, write_enable;
  logic [4:0]  write_add;
  logic [31:0] z5_output, busy;
  int total = 0;
  int bad = 0;

  regfile_wb_sched #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_add(a_add), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_add(b_add), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_rd(issue_rd),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .stall(stall),
    .write_enable(write_enable), .write_add(write_add), .z5_output(z5_output), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [36:0] mfifo[$];
  logic [37:0] exp_q[$];
  int          mstarve = 0;
  logic [31:0] mbusy = '0;
  logic        m_com = 1'b0;
  logic [37:0] e_mon;

  function automatic bit m_aready();
    return a_valid && !(mfifo.size() != 0 && mstarve >= 4);
  endfunction

  function automatic bit m_stall();
    return issue_valid && (mbusy[issue_rs1] || mbusy[issue_rs2] || (issue_writes && mbusy[issue_rd]));
  endfunction

  // Reference model: evaluates the cycle's arbitration from its own state and queues the commit.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mfifo.delete();
      exp_q.delete();
      mstarve = 0;
      mbusy = '0;
      m_com = 1'b0;
    end else begin
      automatic int n = mfifo.size();
      automatic bit aw = m_aready();
      automatic bit st = m_stall();
      automatic logic [36:0] w = {a_add, a_data};
      m_com = aw || n != 0;
      if (!aw && n != 0) w = mfifo.pop_front();
      if (m_com) exp_q.push_back({w[36:32] != 5'd0, w});
      mstarve = (n != 0 && aw) ? (mstarve == 15 ? 15 : mstarve + 1) : 0;
      if (b_valid && n < 2) mfifo.push_back({b_add, b_data});
      if (m_com) mbusy[w[36:32]] = 1'b0;
      if (!st && issue_valid && issue_writes) mbusy[issue_rd] = 1'b1;
      mbusy[0] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (m_com && exp_q.size() != 0) begin
        e_mon = exp_q.pop_front();
        if (e_mon[37] ? ({write_enable, write_add, z5_output} !== e_mon) : (write_enable !== 1'b0)) begin
          bad++;
          $display("FAIL commit: got we=%b add=%0d data=%h want we=%b add=%0d data=%h",
                   write_enable, write_add, z5_output, e_mon[37], e_mon[36:32], e_mon[31:0]);
        end
      end else if (write_enable !== 1'b0) begin
        bad++;
        $display("FAIL idle_we: got %b want 0", write_enable);
      end
      total++;
      if (a_ready !== m_aready()) begin bad++; $display("FAIL a_ready: got %b want %b", a_ready, m_aready()); end
      total++;
      if (b_ready !== (mfifo.size() < 2)) begin bad++; $display("FAIL b_ready: got %b want %b", b_ready, mfifo.size() < 2); end
      total++;
      if (stall !== m_stall()) begin bad++; $display("FAIL stall: got %b want %b", stall, m_stall()); end
      total++;
      if (busy !== mbusy) begin bad++; $display("FAIL busy: got %h want %h", busy, mbusy); end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_valid = 0; b_valid = 0; issue_valid = 0; issue_writes = 0;
    issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL rst_we: got %b want 0", write_enable); end
    total++; if (write_add !== 5'd0) begin bad++; $display("FAIL rst_add: got %0d want 0", write_add); end
    total++; if (z5_output !== 32'd0) begin bad++; $display("FAIL rst_data: got %h want 0", z5_output); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL rst_busy: got %h want 0", busy); end
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL rst_b_ready: got %b want 1", b_ready); end
    cyc();
    reset = 0;
  endtask

  task automatic test_a_write();
    issue_valid = 1; issue_writes = 1; issue_rd = 5;
    cyc();
    idle();
    #1;
    total++; if (busy[5] !== 1'b1) begin bad++; $display("FAIL a_busy_set: got %b want 1", busy[5]); end
    a_valid = 1; a_add = 5; a_data = 32'h1234;
    #1;
    total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL a_ready_r5: got %b want 1", a_ready); end
    cyc();
    idle();
    #1;
    total++; if (write_enable !== 1'b1) begin bad++; $display("FAIL a_we: got %b want 1", write_enable); end
    total++; if (write_add !== 5'd5) begin bad++; $display("FAIL a_add: got %0d want 5", write_add); end
    total++; if (z5_output !== 32'h00001234) begin bad++; $display("FAIL a_data: got %h want 00001234", z5_output); end
    total++; if (busy[5] !== 1'b0) begin bad++; $display("FAIL a_busy_clr: got %b want 0", busy[5]); end
  endtask

  task automatic test_b_fifo();
    a_valid = 1; a_add = 10; a_data = 32'hA; b_valid = 1; b_add = 7; b_data = 7;
    cyc();
    a_data = 32'hB; b_add = 8; b_data = 8;
    cyc();
    idle();
    #1;
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL b_full: got %b want 0", b_ready); end
    cyc();
    #1;
    total++; if (write_add !== 5'd7 || z5_output !== 32'd7) begin bad++; $display("FAIL b_r7: got %0d/%h want 7/7", write_add, z5_output); end
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL b_not_full: got %b want 1", b_ready); end
    cyc();
    #1;
    total++; if (write_enable !== 1'b1 || write_add !== 5'd8 || z5_output !== 32'd8) begin bad++; $display("FAIL b_r8: got %b/%0d/%h want 1/8/8", write_enable, write_add, z5_output); end
    cyc();
  endtask

  task automatic test_starve();
    for (int i = 0; i <= 12; i++) begin
      a_valid = 1; a_add = 11; a_data = 32'h100 + ((i == 6 || i == 12) ? i - 1 : i);
      b_valid = (i == 0 || i == 6); b_add = (i == 0) ? 5'd9 : 5'd12; b_data = 32'h900 + i;
      #1;
      total++; if (a_ready !== !(i == 5 || i == 11)) begin bad++; $display("FAIL starve_a_ready[%0d]: got %b want %b", i, a_ready, !(i == 5 || i == 11)); end
      cyc();
      if (i == 5 || i == 11) begin
        total++; if (write_add !== ((i == 5) ? 5'd9 : 5'd12)) begin bad++; $display("FAIL starve_forced[%0d]: got %0d want %0d", i, write_add, (i == 5) ? 9 : 12); end
      end
    end
    idle();
    cyc();
  endtask

  task automatic test_hazard();
    issue_valid = 1; issue_writes = 1; issue_rd = 3;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hz_first: got %b want 0", stall); end
    cyc();
    issue_writes = 0; issue_rd = 0; issue_rs1 = 3;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL hz_raw1: got %b want 1", stall); end
    cyc();
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL hz_raw1_hold: got %b want 1", stall); end
    issue_rs1 = 0; issue_rs2 = 3;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL hz_raw2: got %b want 1", stall); end
    issue_rs2 = 0; issue_writes = 1; issue_rd = 3;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL hz_waw: got %b want 1", stall); end
    cyc();
    issue_writes = 0; issue_rd = 0; issue_rs1 = 3;
    a_valid = 1; a_add = 3; a_data = 32'h33;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL hz_no_bypass: got %b want 1", stall); end
    cyc();
    a_valid = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hz_resolved: got %b want 0", stall); end
    total++; if (busy[3] !== 1'b0) begin bad++; $display("FAIL hz_busy3: got %b want 0", busy[3]); end
    idle();
    cyc();
  endtask

  task automatic test_r0();
    a_valid = 1; a_add = 0; a_data = 32'hFFFFFFFF;
    issue_valid = 1; issue_writes = 1; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL r0_stall: got %b want 0", stall); end
    cyc();
    idle();
    #1;
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL r0_we: got %b want 0", write_enable); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL r0_busy: got %h want 0", busy); end
    cyc();
  endtask

  task automatic test_async_reset();
    issue_valid = 1; issue_writes = 1; issue_rd = 4;
    a_valid = 1; a_add = 20; a_data = 32'h2020; b_valid = 1; b_add = 13; b_data = 32'h1313;
    cyc();
    issue_rd = 8; a_add = 21; a_data = 32'h2121; b_add = 14; b_data = 32'h1414;
    cyc();
    idle();
    #1;
    total++; if (busy !== 32'h00000110) begin bad++; $display("FAIL ar_busy_pre: got %h want 00000110", busy); end
    total++; if (b_ready !== 1'b0) begin bad++; $display("FAIL ar_full_pre: got %b want 0", b_ready); end
    total++; if (write_enable !== 1'b1 || write_add !== 5'd21) begin bad++; $display("FAIL ar_pre_commit: got %b/%0d want 1/21", write_enable, write_add); end
    #1;
    reset = 1;
    #1;
    total++; if (write_enable !== 1'b0 || write_add !== 5'd0 || z5_output !== 32'd0) begin bad++; $display("FAIL ar_outputs: got %b/%0d/%h want 0/0/0", write_enable, write_add, z5_output); end
    total++; if (busy !== 32'd0) begin bad++; $display("FAIL ar_busy: got %h want 0", busy); end
    cyc();
    reset = 0;
    #1;
    total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL ar_b_ready: got %b want 1", b_ready); end
    cyc();
    #1;
    total++; if (write_enable !== 1'b0) begin bad++; $display("FAIL ar_fifo_flushed: got %b want 0", write_enable); end
  endtask

  initial begin
    reset = 1;
    a_add = 0; a_data = 0; b_add = 0; b_data = 0;
    idle();
    test_reset();
    test_a_write();
    test_b_fifo();
    test_starve();
    test_hazard();
    test_r0();
    test_async_reset();
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_wb_sched.md
Name: regfile_wb_sched

Overview:
- Writeback scheduler and scoreboard for the 32x32 register file.
- Shares the single regfile write port between two sources:
  - source A: single-cycle ALU path, normally has priority.
  - source B: long-latency unit (load/multiply), buffered in a small FIFO.
- Tracks pending destination registers and stalls decode on RAW/WAW hazards.
- Sits between the stage-4/5 pipeline registers and the regfile write inputs (write_enable, write_add, z5_output).

Parameters:
- FIFO_DEPTH, 2, entries in the source-B buffer; power of 2, minimum 2.
- STARVE_LIMIT, 4, consecutive cycles a non-empty B FIFO may lose to A before B is forced through; range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_valid  input  1  ALU writeback request.
- a_add  input  5  ALU destination register.
- a_data  input  32  ALU result.
- a_ready  output  1  A accepted this cycle (combinational).
- b_valid  input  1  long-latency writeback request.
- b_add  input  5  B destination register.
- b_data  input  32  B result.
- b_ready  output  1  FIFO not full (combinational).
- issue_valid  input  1  decode presents an instruction.
- issue_writes  input  1  the instruction writes issue_rd.
- issue_rd  input  5  destination register.
- issue_rs1  input  5  source register 1.
- issue_rs2  input  5  source register 2.
- stall  output  1  decode must hold (combinational).
- write_enable  output  1  to regfile write_enable (registered).
- write_add  output  5  to regfile write_add (registered).
- z5_output  output  32  to regfile z5_output (registered).
- busy  output  32  scoreboard bits, for debug and bench.

Behaviour:
- Reset (asynchronous, active-high): write_enable=0, write_add=0, z5_output=0, busy=0, FIFO empty, starve counter=0. Reset mid-operation discards FIFO contents and all pending busy bits.
- B enqueue: when b_valid && b_ready, {b_add, b_data} is pushed at the clock edge. b_ready = (count < FIFO_DEPTH). A push and a pop in the same cycle with a full FIFO is not permitted: b_ready stays 0 when full.
- Arbitration, evaluated each cycle:
  - force_b = FIFO non-empty && starve_cnt >= STARVE_LIMIT.
  - If a_valid && !force_b: A wins, a_ready=1.
  - Else if FIFO non-empty: head is popped; a_ready=0.
  - Else: no commit, a_ready=0.
- Starve counter:
  - Increments (saturating at 15) when the FIFO is non-empty and A wins.
  - Clears when B wins or the FIFO is empty.
- Commit: the winner's address and data are registered onto write_add/z5_output, with write_enable=1, one cycle after acceptance (latency 1).
  - A winner with address 0 produces write_enable=0; r0 is never written.
  - Idle cycles: write_enable=0; write_add and z5_output hold their last values.
- Scoreboard:
  - Set: on issue_valid && !stall && issue_writes && issue_rd!=0, busy[issue_rd] is set at the edge.
  - Clear: on commit (the edge where the winner is accepted), busy[winner address] is cleared. Clearing an already-clear bit is harmless.
  - busy[0] is always 0.
- Stall: stall = issue_valid && (busy[rs1] || busy[rs2] || (issue_writes && busy[rd])).
  - Uses registered busy only; no bypass from a same-cycle commit. The hazard resolves the cycle after the clear.
  - Because WAW stalls, a set and a clear of the same register never coincide.
- Accepting A with valid=0 is impossible. A, when not ready, must hold its request stable.
- Ordering: B entries commit in FIFO order. A and B may commit to different registers in any interleaving.

Test Plan:
- Reset, then A writes r5=0x1234 -> next cycle write_enable=1, write_add=5, z5_output=0x00001234; busy[5] cleared on the same edge as acceptance.
- Two B pushes (r7=7, r8=8) with A idle -> commits r7 then r8 on consecutive cycles; b_ready=0 only while count=2.
- FIFO holds r9 while a_valid is held continuously -> A wins 4 cycles; on the 5th cycle a_ready=0 and r9 commits; the counter then returns to 0.
- Issue rd=3, then issue rs1=3 -> stall=1 until the cycle after r3 commits, then 0. Issue rd=3 again while busy[3] -> stall (WAW).
- A write to r0 with data 0xFFFFFFFF -> write_enable stays 0; busy[0] stays 0; issue with rs1=0 never stalls.
- Assert reset asynchronously with 2 FIFO entries and busy=0x00000110 -> outputs and busy go to 0 immediately, before the next edge; b_ready=1 after release.
